// File: rtl/maze_pkg.sv
// Shared types and constants for the maze controller: FSM states, move
// directions, maze dimensions and block-coordinate width.
package maze_pkg;

  localparam int MAZE_COLS = 40;
  localparam int MAZE_ROWS = 30;
  localparam int BCOORD_W  = 6;

  typedef logic [BCOORD_W-1:0] bcoord_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_RD    = 3'd2,
    ST_CHECK = 3'd3,
    ST_WIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Priority pick up > down > left > right. Only called when at least one
  // button is pressed, so "none of up/down/left" implies right.
  function automatic dir_e pick_dir(input logic up, input logic down,
                                    input logic left);
    if (up)        return DIR_UP;
    else if (down) return DIR_DOWN;
    else if (left) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/maze_move_timer.sv
// Frame-tick counter that paces player moves. move_ok goes high once
// MOVE_FRAMES-1 ticks have been counted and stays high until a move
// attempt reloads the counter to zero.
module maze_move_timer #(
  parameter int MOVE_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic reload,
  output logic move_ok
);

  localparam logic [7:0] LAST = 8'(MOVE_FRAMES - 1);

  logic [7:0] count;

  // Count ticks up to LAST and hold there; a move attempt restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (reload) begin
      count <= '0;
    end else if (frame_tick && (count != LAST)) begin
      count <= count + 8'd1;
    end
  end

  assign move_ok = (count == LAST);

endmodule

// File: rtl/maze_controller.sv
// Maze player controller: paces button presses with a frame-tick timer,
// computes the target block, reads the maze ROM for a wall and moves the
// player if the way is clear. Reaching the exit block latches WIN.
// Optional feature macro MAZE_STEP_CNT_EN adds a saturating 10-bit
// successful-move counter on o_steps.
//
// Handshake: none of the interfaces use valid/ready; the ROM is a fixed
// one-cycle-latency read whose address is held through RD and CHECK, so
// i_rom_wall sampled in CHECK belongs to the address presented in RD.
module maze_controller
  import maze_pkg::*;
#(
  parameter int MOVE_FRAMES = 8,
  parameter int START_BCOL  = 1,
  parameter int START_BROW  = 1,
  parameter int EXIT_BCOL   = 37,
  parameter int EXIT_BROW   = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  output logic [11:0] o_rom_addr,
  input  logic        i_rom_wall,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_win,
`ifdef MAZE_STEP_CNT_EN
  output logic [9:0]  o_steps,
`endif
  output state_e      o_dbg_state
);

  localparam bcoord_t START_C = bcoord_t'(START_BCOL);
  localparam bcoord_t START_R = bcoord_t'(START_BROW);
  localparam bcoord_t EXIT_C  = bcoord_t'(EXIT_BCOL);
  localparam bcoord_t EXIT_R  = bcoord_t'(EXIT_BROW);
  localparam bcoord_t LAST_C  = bcoord_t'(MAZE_COLS - 1);
  localparam bcoord_t LAST_R  = bcoord_t'(MAZE_ROWS - 1);

  state_e  state, state_nxt;
  dir_e    dir_q;
  bcoord_t bcol, brow;
  bcoord_t tgt_bcol, tgt_brow;
  bcoord_t calc_bcol, calc_brow;
  logic    calc_ok;
  logic    any_btn, move_ok, accept;
  logic    tgt_load, pos_load;

  assign any_btn = i_up | i_down | i_left | i_right;
  assign accept  = (state == ST_IDLE) && i_frame_tick && move_ok && any_btn;

  maze_move_timer #(
    .MOVE_FRAMES(MOVE_FRAMES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(i_frame_tick),
    .reload    (accept),
    .move_ok   (move_ok)
  );

  // Target block for the latched direction, with grid-edge rejection (no wrap).
  always_comb begin
    calc_bcol = bcol;
    calc_brow = brow;
    calc_ok   = 1'b1;
    case (dir_q)
      DIR_UP: begin
        calc_brow = brow - 6'd1;
        calc_ok   = (brow != '0);
      end
      DIR_DOWN: begin
        calc_brow = brow + 6'd1;
        calc_ok   = (brow < LAST_R);
      end
      DIR_LEFT: begin
        calc_bcol = bcol - 6'd1;
        calc_ok   = (bcol != '0);
      end
      default: begin
        calc_bcol = bcol + 6'd1;
        calc_ok   = (bcol < LAST_C);
      end
    endcase
  end

  // Next-state logic and load strobes for target and position registers.
  always_comb begin
    state_nxt = state;
    tgt_load  = 1'b0;
    pos_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (calc_ok) begin
          tgt_load  = 1'b1;
          state_nxt = ST_RD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!i_rom_wall) begin
          pos_load  = 1'b1;
          state_nxt = ((tgt_bcol == EXIT_C) && (tgt_brow == EXIT_R)) ? ST_WIN : ST_IDLE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WIN: begin
        state_nxt = ST_WIN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Direction latch: captured on the cycle the move attempt is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dir_q <= DIR_UP;
    else if (accept) dir_q <= pick_dir(i_up, i_down, i_left);
  end

  // Target block register, loaded in CALC when the target is on the grid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_bcol <= START_C;
      tgt_brow <= START_R;
    end else if (tgt_load) begin
      tgt_bcol <= calc_bcol;
      tgt_brow <= calc_brow;
    end
  end

  // Player position, committed in CHECK when the ROM reports no wall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcol <= START_C;
      brow <= START_R;
    end else if (pos_load) begin
      bcol <= tgt_bcol;
      brow <= tgt_brow;
    end
  end

`ifdef MAZE_STEP_CNT_EN
  logic [9:0] steps;

  // Successful-move counter, saturating at 1023.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             steps <= '0;
    else if (pos_load && (steps != 10'h3FF)) steps <= steps + 10'd1;
  end

  assign o_steps = steps;
`endif

  assign o_rom_addr    = ((state == ST_RD) || (state == ST_CHECK)) ? {tgt_brow, tgt_bcol}
                                                                   : {brow, bcol};
  assign o_player_bcol = bcol;
  assign o_player_brow = brow;
  assign o_exit_bcol   = EXIT_C;
  assign o_exit_brow   = EXIT_R;
  assign o_win         = (state == ST_WIN);
  assign o_dbg_state   = state;

endmodule

// File: tb/tb_maze_controller.sv
// Directed bench for maze_controller. Drivers issue frame ticks with buttons
// held and push the expected outcome of each move attempt; a monitor detects
// each completed attempt from the FSM state and compares it.
module tb_maze_controller;
  import maze_pkg::*;

  localparam int MF = 2;
  localparam int EW = 26;  // {rom_used, rd_addr[11:0], brow[5:0], bcol[5:0], win}

  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [11:0] rom_addr;
  logic        rom_wall = 1'b0;
  logic [5:0]  bcol, brow, exit_bcol, exit_brow;
  logic        win;
  state_e      dbg_state;
`ifdef MAZE_STEP_CNT_EN
  logic [9:0]  steps;
`endif

  maze_controller #(
    .MOVE_FRAMES(MF),
    .START_BCOL (1),
    .START_BROW (1),
    .EXIT_BCOL  (37),
    .EXIT_BROW  (22)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_tick (frame_tick),
    .i_up         (up),
    .i_down       (down),
    .i_left       (left),
    .i_right      (right),
    .o_rom_addr   (rom_addr),
    .i_rom_wall   (rom_wall),
    .o_player_bcol(bcol),
    .o_player_brow(brow),
    .o_exit_bcol  (exit_bcol),
    .o_exit_brow  (exit_brow),
    .o_win        (win),
`ifdef MAZE_STEP_CNT_EN
    .o_steps      (steps),
`endif
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: one-cycle read latency, a single optional wall block.
  logic        wall_en = 1'b0;
  logic [11:0] wall_addr = 12'h000;
  always @(posedge clk) rom_wall <= wall_en && (rom_addr == wall_addr);

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            checks = 0;
  int            errors = 0;
  int            tick_cyc = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got used=%0b addr=%h brow=%0d bcol=%0d win=%0b expected used=%0b addr=%h brow=%0d bcol=%0d win=%0b",
               name, act[25], act[24:13], act[12:7], act[6:1], act[0],
               exp[25], exp[24:13], exp[12:7], exp[6:1], exp[0]);
    end
  endtask

  function automatic logic [11:0] mk_addr(input int r, input int c);
    return {6'(r), 6'(c)};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    state_e        prev_st;
    logic          rom_seen;
    logic [11:0]   rd_addr;
    logic [EW-1:0] act, exp;
    int            ec;
    prev_st  = ST_IDLE;
    rom_seen = 1'b0;
    rd_addr  = 12'h000;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_st  = ST_IDLE;
        rom_seen = 1'b0;
      end else begin
        if (dbg_state == ST_RD) begin
          rom_seen = 1'b1;
          rd_addr  = rom_addr;
        end
        if (((dbg_state == ST_IDLE) || (dbg_state == ST_WIN)) &&
            ((prev_st == ST_CALC) || (prev_st == ST_CHECK))) begin
          act = {rom_seen, (rom_seen ? rd_addr : 12'h000), brow, bcol, win};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_move: got brow=%0d bcol=%0d at cycle %0d expected no attempt",
                     brow, bcol, cyc);
          end else begin
            exp = exp_q.pop_front();
            ec  = exp_cyc_q.pop_front();
            check_vec("move_result", act, exp);
            check_int("move_latency_cycle", cyc, ec);
          end
          check_int("idle_rom_addr", int'(rom_addr), int'({brow, bcol}));
          rom_seen = 1'b0;
        end
        prev_st = dbg_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_btn(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    tick_cyc   = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic push_exp(input logic used, input logic [11:0] addr, input int r,
                          input int c, input logic w, input int lat);
    exp_q.push_back({used, addr, 6'(r), 6'(c), w});
    exp_cyc_q.push_back(tick_cyc + lat);
  endtask

  task automatic wait_drain();
    for (int i = 0; (i < 20) && (exp_q.size() != 0); i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL move_timeout: got %0d pending attempts expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // One full move: MF-1 arming ticks, then the tick that triggers the attempt.
  task automatic step(input logic [3:0] b, input logic used, input logic [11:0] addr,
                      input int r, input int c, input logic w, input int lat);
    set_btn(b);
    repeat (MF - 1) begin
      pulse_tick();
      repeat (3) @(negedge clk);
    end
    pulse_tick();
    push_exp(used, addr, r, c, w, lat);
    wait_drain();
    set_btn(4'b0000);
  endtask

  task automatic move_to(input logic [3:0] b, input int r, input int c);
    step(b, 1'b1, mk_addr(r, c), r, c, 1'b0, 4);
  endtask

  task automatic blocked_edge(input logic [3:0] b, input int r, input int c);
    step(b, 1'b0, 12'h000, r, c, 1'b0, 2);
  endtask

  task automatic check_home(input string tag);
    check_int({tag, "_bcol"}, int'(bcol), 1);
    check_int({tag, "_brow"}, int'(brow), 1);
    check_int({tag, "_win"}, int'(win), 0);
    check_int({tag, "_rom_addr"}, int'(rom_addr), 'h041);
    check_int({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
`ifdef MAZE_STEP_CNT_EN
    check_int({tag, "_steps"}, int'(steps), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_btn(4'b0000);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_home("reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state and constant exit outputs.
    do_reset();
    check_int("exit_bcol", int'(exit_bcol), 37);
    check_int("exit_brow", int'(exit_brow), 22);

    // Wall at (brow 1, bcol 2): ROM read of 0x042, no movement.
    wall_en   = 1'b1;
    wall_addr = 12'h042;
    step(B_RIGHT, 1'b1, 12'h042, 1, 1, 1'b0, 4);
    wall_en   = 1'b0;

    // Right held: move on every 2nd tick, 4 edges after the tick.
    do_reset();
    set_btn(B_RIGHT);
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    push_exp(1'b1, 12'h042, 1, 2, 1'b0, 4);
    wait_drain();
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    push_exp(1'b1, 12'h043, 1, 3, 1'b0, 4);
    wait_drain();
    // A tick landing in RD is no move but still arms the timer.
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    push_exp(1'b1, 12'h044, 1, 4, 1'b0, 4);
    pulse_tick();
    wait_drain();
    pulse_tick();
    push_exp(1'b1, 12'h045, 1, 5, 1'b0, 4);
    wait_drain();
    set_btn(4'b0000);
`ifdef MAZE_STEP_CNT_EN
    check_int("steps_after_four", int'(steps), 4);
`endif

    // Left edge and bottom edge: no ROM access, no wrap.
    do_reset();
    move_to(B_LEFT, 1, 0);
    blocked_edge(B_LEFT, 1, 0);
    for (int r = 2; r <= 29; r++) move_to(B_DOWN, r, 0);
    blocked_edge(B_DOWN, 29, 0);

    // Up+right at (5,5): up wins.
    do_reset();
    for (int r = 2; r <= 5; r++) move_to(B_DOWN, r, 1);
    for (int c = 2; c <= 5; c++) move_to(B_RIGHT, 5, c);
    step(B_UP | B_RIGHT, 1'b1, 12'h105, 4, 5, 1'b0, 4);

    // Right edge, then walk to (bcol 36, brow 22) and step onto the exit.
    for (int c = 6; c <= 39; c++) move_to(B_RIGHT, 4, c);
    blocked_edge(B_RIGHT, 4, 39);
    for (int c = 38; c >= 36; c--) move_to(B_LEFT, 4, c);
    for (int r = 5; r <= 22; r++) move_to(B_DOWN, r, 36);
    step(B_RIGHT, 1'b1, 12'h5A5, 22, 37, 1'b1, 4);

    // WIN is terminal: buttons and ticks are ignored.
    set_btn(4'b1111);
    repeat (4) begin
      pulse_tick();
      repeat (3) @(negedge clk);
    end
    set_btn(4'b0000);
    check_int("win_frozen_bcol", int'(bcol), 37);
    check_int("win_frozen_brow", int'(brow), 22);
    check_int("win_held", int'(win), 1);
    check_int("win_state", int'(dbg_state), int'(ST_WIN));
`ifdef MAZE_STEP_CNT_EN
    check_int("steps_at_win", int'(steps), 65);
`endif

    // Reset asserted while the FSM sits in RD: pending target discarded.
    do_reset();
    set_btn(B_RIGHT);
    pulse_tick();
    repeat (3) @(negedge clk);
    pulse_tick();
    for (int i = 0; (i < 5) && (dbg_state != ST_RD); i++) @(negedge clk);
    check_int("reached_rd", int'(dbg_state), int'(ST_RD));
    #2 rst = 1'b0;
    #1 check_home("reset_in_rd");
    set_btn(4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // First move after reset still needs MF ticks.
    move_to(B_RIGHT, 1, 2);

    repeat (4) @(negedge clk);
    check_int("pending_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/maze_controller.md
MAZE_CONTROLLER -- requirements
Module: maze_controller

Interface
REQ-001 Parameters (name, default, meaning): MOVE_FRAMES, 8, frame ticks between consecutive moves (1..255).
REQ-002 START_BCOL / START_BROW, 1 / 1, player block position after reset.
REQ-003 EXIT_BCOL / EXIT_BROW, 37 / 22, exit block position.
REQ-004 Ports (name, direction, width, meaning): clk, in, 1, the single clock; rst, in, 1, asynchronous active-low reset.
REQ-005 i_frame_tick, in, 1, one-cycle pulse at start of each vertical blank.
REQ-006 i_up / i_down / i_left / i_right, in, 1 each, synchronized button levels.
REQ-007 o_rom_addr, out, 12, maze ROM address {brow[5:0], bcol[5:0]}.
REQ-008 i_rom_wall, in, 1, ROM data, 1 = wall; valid exactly one cycle after o_rom_addr changes.
REQ-009 o_player_bcol / o_player_brow, out, 6 each, current player block position.
REQ-010 o_exit_bcol / o_exit_brow, out, 6 each, constant EXIT_BCOL / EXIT_BROW.
REQ-011 o_win, out, 1, high while player occupies exit block.

Function
REQ-012 FSM states: IDLE, CALC, RD, CHECK, WIN.
REQ-013 Move timer counts i_frame_tick pulses; "move_ok" asserted when count has reached MOVE_FRAMES-1; count reloads to 0 on each accepted move attempt.
REQ-014 IDLE -> CALC on cycle where i_frame_tick=1, move_ok=1 and any direction is pressed; otherwise remain IDLE.
REQ-015 Direction priority when several pressed: up > down > left > right; exactly one direction is latched in CALC.
REQ-016 CALC computes target: up = brow-1, down = brow+1, left = bcol-1, right = bcol+1, 6-bit arithmetic.
REQ-017 Target outside grid (bcol > 39, brow > 29, or decrement below 0) -> return to IDLE, no ROM access, position unchanged; no wrap-around.
REQ-018 CALC -> RD with o_rom_addr = {target_brow, target_bcol}; RD -> CHECK after one cycle.
REQ-019 CHECK: i_rom_wall=0 -> position := target, next state WIN if target equals exit, else IDLE; i_rom_wall=1 -> position unchanged, IDLE.
REQ-020 Position updates on the 4th rising edge after the frame-tick cycle (IDLE->CALC->RD->CHECK->update).
REQ-021 i_frame_tick arriving while not in IDLE is ignored for moves but still advances the move timer.
REQ-022 WIN is terminal: o_win=1, position frozen, buttons ignored until reset.
REQ-023 o_rom_addr outside RD/CHECK holds {player_brow, player_bcol}.

Reset
REQ-024 rst low asynchronously forces: state IDLE, position (START_BCOL, START_BROW), move timer 0, o_win 0, o_rom_addr {START_BROW, START_BCOL}; applies mid-move, discarding any pending target.
REQ-025 Reset deassertion takes effect on next clk edge; first move requires MOVE_FRAMES frame ticks.

Configuration
REQ-026 Macro MAZE_STEP_CNT_EN defined: extra output o_steps, 10 bits, counts successful moves, saturates at 1023, reset to 0.
REQ-027 MAZE_STEP_CNT_EN undefined: o_steps port and counter absent; all other behaviour identical.

Structure
REQ-028 Package maze_pkg holds: state enum, direction enum, MAZE_COLS=40, MAZE_ROWS=30, block-coordinate width 6.
REQ-029 Sub-module maze_move_timer (frame-tick counter with reload, move_ok output) is instantiated once.

Verification
REQ-030 Reset, MOVE_FRAMES=2, right held, ROM all 0 -> bcol 1->2 after 2nd tick, 2->3 after 4th tick; update 4 cycles after tick.
REQ-031 Wall at (brow1,bcol2), right held -> o_rom_addr=0x042 in RD, position stays (1,1).
REQ-032 Player at bcol 0, left held -> no ROM access, position unchanged; brow 29 down -> unchanged.
REQ-033 up+right held at (5,5), ROM 0 -> brow becomes 4, bcol stays 5.
REQ-034 Move from (36,22) right, ROM 0 -> position (37,22), o_win=1 next cycle, further buttons ignored.
REQ-035 rst low during RD -> immediate return to (1,1), o_win 0; with MAZE_STEP_CNT_EN, o_steps 0.
